// File: rtl/io_cond_pkg.sv
// Shared definitions for the board I/O conditioner: LED mode encodings,
// default timing constants and a counter-width helper.
package io_cond_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_PWM       = 2'b01,
    MODE_BLINK     = 2'b10,
    MODE_PWM_BLINK = 2'b11
  } ld_mode_e;

  localparam int DEF_DB_CYCLES    = 1000000;
  localparam int DEF_BLINK_CYCLES = 25000000;

  // Width of a counter spanning 0..n_states-1, never narrower than one bit.
  function automatic int cnt_width(input int n_states);
    return (n_states > 1) ? $clog2(n_states) : 1;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-FF synchroniser, debounce counter, stable level and
// one-cycle rise/fall flags aligned with the first cycle of the new level.
module debounce_ch
  import io_cond_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          rise_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, count disagreement cycles and accept the new level on the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      if (sync2_r == stable_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r    <= {CW{1'b0}};
        stable_r <= sync2_r;
        rise_r   <= sync2_r;
        fall_r   <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign level = stable_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/board_io_conditioner.sv
// Board-I/O front end: debounced buttons/switches with edge pulses, and LED
// drive in direct, PWM-dimmed, blink or dimmed-blink mode.
module board_io_conditioner
  import io_cond_pkg::*;
#(
  parameter int NUM_BTN      = 5,
  parameter int NUM_SW       = 8,
  parameter int NUM_LD       = 8,
  parameter int DB_CYCLES    = DEF_DB_CYCLES,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
  input  logic                GCLK,
  input  logic                RST,
  input  logic [NUM_BTN-1:0]  BTN_IN,
  input  logic [NUM_SW-1:0]   SW_IN,
  output logic [NUM_BTN-1:0]  BTN_LEVEL,
  output logic [NUM_BTN-1:0]  BTN_PRESS,
  output logic [NUM_BTN-1:0]  BTN_RELEASE,
  output logic [NUM_SW-1:0]   SW_LEVEL,
  output logic                SW_CHANGE,
  input  logic [NUM_LD-1:0]   LD_VAL,
  input  logic [PWM_BITS-1:0] LD_BRIGHT,
  input  logic [1:0]          LD_MODE,
  output logic [NUM_LD-1:0]   LD
);

  localparam int BW = cnt_width(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [NUM_SW-1:0]   sw_rise_s;
  logic [NUM_SW-1:0]   sw_fall_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [BW-1:0]       blink_cnt_r;
  logic                blink_ph_r;
  logic                pwm_on_s;
  logic                gate_s;
  logic [NUM_LD-1:0]   ld_r;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (GCLK),
      .rst   (RST),
      .din   (BTN_IN[i]),
      .level (BTN_LEVEL[i]),
      .rise  (BTN_PRESS[i]),
      .fall  (BTN_RELEASE[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (GCLK),
      .rst   (RST),
      .din   (SW_IN[i]),
      .level (SW_LEVEL[i]),
      .rise  (sw_rise_s[i]),
      .fall  (sw_fall_s[i])
    );
  end

  // The per-channel flags are already registered, so the OR stays cycle-aligned with SW_LEVEL.
  assign SW_CHANGE = |(sw_rise_s | sw_fall_s);

  // Brightness all-ones forces fully on; otherwise on while the counter is below the duty.
  always_comb begin
    pwm_on_s = (LD_BRIGHT == {PWM_BITS{1'b1}}) | (pwm_cnt_r < LD_BRIGHT);
  end

  // Select the LED gate for the requested mode.
  always_comb begin
    gate_s = 1'b0;
    case (ld_mode_e'(LD_MODE))
      MODE_DIRECT:    gate_s = 1'b1;
      MODE_PWM:       gate_s = pwm_on_s;
      MODE_BLINK:     gate_s = blink_ph_r;
      MODE_PWM_BLINK: gate_s = pwm_on_s & blink_ph_r;
      default:        gate_s = 1'b0;
    endcase
  end

  // Free-running PWM/blink timebase and registered LED drive; mode never resets the counters.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= 1'b0;
      ld_r        <= {NUM_LD{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 1'b1;
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
      ld_r <= LD_VAL & {NUM_LD{gate_s}};
    end
  end

  assign LD = ld_r;

endmodule
